// File: rtl/l2_pmem_responder.sv
// Full-line physical-memory responder below L2: one read or write per request, fixed per-direction latency.
// Optional protocol checker enabled by defining L2_PMEM_PROTOCOL_CHECK_EN; otherwise pmem_err is tied 0.
module l2_pmem_responder #(
  parameter int LINE_BITS     = 256,
  parameter int INDEX_BITS    = 8,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [31:0]          pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_resp,
  output logic                 pmem_err,
  output logic [1:0]           dbg_state
);

  localparam int OFF     = $clog2(LINE_BITS / 8);
  localparam int DEPTH   = 1 << INDEX_BITS;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Handshake: a request line high in IDLE is accepted at that edge and must stay
  // high (address/data stable) through the single pmem_resp cycle.

  logic [LINE_BITS-1:0] mem [DEPTH];

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic                 mem_we;
  logic                 accept;
  logic [INDEX_BITS-1:0] idx;
  logic                 unused_addr;

  assign idx         = pmem_address[OFF +: INDEX_BITS];
  assign unused_addr = ^pmem_address;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pmem_read || pmem_write) begin
          accept = 1'b1;
          // Write wins when both request lines are high.
          if (pmem_write) begin
            mem_we  = 1'b1;
            cnt_d   = CNT_W'(WRITE_LATENCY - 1);
            state_d = (WRITE_LATENCY == 1) ? S_RESP : S_BUSY;
          end else begin
            rdata_d = mem[idx];
            cnt_d   = CNT_W'(READ_LATENCY - 1);
            state_d = (READ_LATENCY == 1) ? S_RESP : S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Line array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= pmem_wdata;
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = (state_q == S_RESP);
  assign dbg_state  = state_q;

`ifdef L2_PMEM_PROTOCOL_CHECK_EN
  logic [31:0]          addr_q, addr_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic                 dir_wr_q, dir_wr_d;
  logic                 err_q, err_d;
  logic                 in_flight;

  assign in_flight = (state_q == S_BUSY) || (state_q == S_RESP);

  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dir_wr_d = dir_wr_q;
    err_d    = err_q;
    if (accept) begin
      addr_d   = pmem_address;
      wdata_d  = pmem_wdata;
      dir_wr_d = pmem_write;
      if (pmem_read && pmem_write) err_d = 1'b1;
    end
    if (in_flight) begin
      if (!pmem_read && !pmem_write) err_d = 1'b1;
      if (pmem_address != addr_q) err_d = 1'b1;
      if ((pmem_write != dir_wr_q) || (pmem_read == dir_wr_q)) err_d = 1'b1;
      if (dir_wr_q && (pmem_wdata != wdata_q)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      dir_wr_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dir_wr_q <= dir_wr_d;
      err_q    <= err_d;
    end
  end

  assign pmem_err = err_q;
`else
  assign pmem_err = 1'b0;
`endif

endmodule
